// File: rtl/bram_bist_if.sv
// BRAM port bundle between the BIST engine (master) and one BRAM port (slave).
// The engine always drives ra and wa with the same address.
interface bram_bist_if #(
  parameter int AWIDTH = 10,
  parameter int DWIDTH = 36
);
  logic              rce;
  logic [AWIDTH-1:0] ra;
  logic [DWIDTH-1:0] rq;
  logic              wce;
  logic [AWIDTH-1:0] wa;
  logic [DWIDTH-1:0] wd;

  modport master (output rce, ra, wce, wa, wd, input rq);
  modport slave  (input rce, ra, wce, wa, wd, output rq);
endinterface

// File: rtl/bram_bist_engine.sv
// March C-style BIST sequencer for one port of a BRAM with a one-cycle
// registered read. It reports pass/fail, the first failing address and word,
// and a saturating mismatch count.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// S_IDLE     | waiting for start_i
// S_W0       | ascending, write P
// S_R0W1_RD  | ascending, read the current address
// S_R0W1_WR  | compare rq against P, write ~P to the same address
// S_R1W0_RD  | descending, read the current address
// S_R1W0_WR  | compare rq against ~P, write P to the same address
// S_R0       | ascending read; compares the word read in the previous cycle
// S_DRAIN    | compare the last R0 word, no BRAM access
// S_DONE     | one-cycle done pulse, pass valid
module bram_bist_engine #(
  parameter int                AWIDTH  = 10,
  parameter int                DWIDTH  = 36,
  parameter logic [DWIDTH-1:0] PATTERN = '0,
  // The error count stops here; full scale unless a smaller ceiling is wanted.
  parameter logic [15:0]       ERR_MAX = 16'hFFFF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              pass_o,
  output logic [15:0]       error_count_o,
  output logic [AWIDTH-1:0] fail_addr_o,
  output logic [DWIDTH-1:0] fail_data_o,
  bram_bist_if.master       bram_m
);

  localparam logic [AWIDTH-1:0] ADDR_LAST = '1;
  localparam logic [DWIDTH-1:0] PAT_C     = ~PATTERN;

  typedef enum logic [3:0] {
    S_IDLE, S_W0, S_R0W1_RD, S_R0W1_WR, S_R1W0_RD, S_R1W0_WR, S_R0, S_DRAIN, S_DONE
  } state_t;

  state_t            state_q;
  logic [AWIDTH-1:0] addr_q;
  logic              rce_q, wce_q;
  logic [DWIDTH-1:0] wd_q;
  logic              busy_q, done_q, pass_q;
  logic [15:0]       err_q;
  logic [AWIDTH-1:0] fail_addr_q;
  logic [DWIDTH-1:0] fail_data_q;

  logic              cmp_en;
  logic [DWIDTH-1:0] cmp_exp;
  logic [AWIDTH-1:0] cmp_addr;
  logic              mismatch;
  logic              first_fail;
  logic [15:0]       err_d;

  // Compare the word read in the previous cycle; only states that follow a read compare.
  always_comb begin
    cmp_en   = 1'b0;
    cmp_exp  = PATTERN;
    cmp_addr = addr_q;
    case (state_q)
      S_R0W1_WR: cmp_en = 1'b1;
      S_R1W0_WR: begin
        cmp_en  = 1'b1;
        cmp_exp = PAT_C;
      end
      // At address 0 the previous cycle was the last R1W0 write, so nothing to compare.
      S_R0: begin
        cmp_en   = (addr_q != '0);
        cmp_addr = addr_q - 1'b1;
      end
      S_DRAIN:   cmp_en = 1'b1;
      default:   cmp_en = 1'b0;
    endcase
    mismatch   = cmp_en && (bram_m.rq != cmp_exp);
    first_fail = mismatch && (err_q == 16'd0);
    err_d      = (mismatch && (err_q != ERR_MAX)) ? err_q + 16'd1 : err_q;
  end

  // March sequencer; BRAM-side and status outputs are registered with the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      rce_q       <= 1'b0;
      wce_q       <= 1'b0;
      wd_q        <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      err_q       <= '0;
      fail_addr_q <= '0;
      fail_data_q <= '0;
    end else begin
      rce_q  <= 1'b0;
      wce_q  <= 1'b0;
      done_q <= 1'b0;
      err_q  <= err_d;
      if (first_fail) begin
        fail_addr_q <= cmp_addr;
        fail_data_q <= bram_m.rq;
      end
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            state_q     <= S_W0;
            addr_q      <= '0;
            wce_q       <= 1'b1;
            wd_q        <= PATTERN;
            busy_q      <= 1'b1;
            pass_q      <= 1'b0;
            err_q       <= '0;
            fail_addr_q <= '0;
            fail_data_q <= '0;
          end
        end
        S_W0: begin
          if (addr_q == ADDR_LAST) begin
            state_q <= S_R0W1_RD;
            addr_q  <= '0;
            rce_q   <= 1'b1;
          end else begin
            addr_q <= addr_q + 1'b1;
            wce_q  <= 1'b1;
            wd_q   <= PATTERN;
          end
        end
        S_R0W1_RD: begin
          state_q <= S_R0W1_WR;
          wce_q   <= 1'b1;
          wd_q    <= PAT_C;
        end
        S_R0W1_WR: begin
          rce_q <= 1'b1;
          if (addr_q == ADDR_LAST) begin
            state_q <= S_R1W0_RD;
          end else begin
            state_q <= S_R0W1_RD;
            addr_q  <= addr_q + 1'b1;
          end
        end
        S_R1W0_RD: begin
          state_q <= S_R1W0_WR;
          wce_q   <= 1'b1;
          wd_q    <= PATTERN;
        end
        S_R1W0_WR: begin
          rce_q <= 1'b1;
          if (addr_q == '0) begin
            state_q <= S_R0;
          end else begin
            state_q <= S_R1W0_RD;
            addr_q  <= addr_q - 1'b1;
          end
        end
        S_R0: begin
          if (addr_q == ADDR_LAST) begin
            state_q <= S_DRAIN;
          end else begin
            addr_q <= addr_q + 1'b1;
            rce_q  <= 1'b1;
          end
        end
        S_DRAIN: begin
          state_q <= S_DONE;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
          pass_q  <= (err_d == 16'd0);
        end
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy_o        = busy_q;
  assign done_o        = done_q;
  assign pass_o        = pass_q;
  assign error_count_o = err_q;
  assign fail_addr_o   = fail_addr_q;
  assign fail_data_o   = fail_data_q;
  assign bram_m.rce    = rce_q;
  assign bram_m.wce    = wce_q;
  assign bram_m.ra     = addr_q;
  assign bram_m.wa     = addr_q;
  assign bram_m.wd     = wd_q;

endmodule
